full_bridge_gate_driver: RTL

Downstream consumer of the pwm block's o_pwm_signal. It converts the single PWM stream into four gate commands for an H-bridge: leg A high/low and leg B high/low. Sign-magnitude steering is set by a direction input. Programmable dead-time insertion makes both switches of a leg off during every transition. A latched fault shutdown forces all gates off.

---
 rtl/full_bridge_pkg.sv | 12 +
 rtl/full_bridge_gate_driver_deadtime_leg.sv | 74 +++++++
 rtl/full_bridge_gate_driver.sv | 50 +++++
 3 files changed

// File: rtl/full_bridge_pkg.sv
// full_bridge_pkg: shared leg state encoding and dead-time constants for the H-bridge gate driver
package full_bridge_pkg;
  localparam int DT_WIDTH_DEF = 8;
  localparam int DT_MIN = 1;
  typedef enum logic [2:0] {
    OFF,
    DEAD_TO_LOW,
    LOW_ON,
    DEAD_TO_HIGH,
    HIGH_ON
  } leg_state_t;
endpackage

// File: rtl/full_bridge_gate_driver_deadtime_leg.sv
// deadtime_leg: one half-bridge leg FSM with dead-time counter and registered gate decodes
module deadtime_leg
  import full_bridge_pkg::*;
#(
  parameter int DT_WIDTH = DT_WIDTH_DEF
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_cmd,
  input  logic                i_force_off,
  input  logic [DT_WIDTH-1:0] i_dead_time,
  output logic                o_high,
  output logic                o_low
);
  leg_state_t state, state_n;
  logic [DT_WIDTH-1:0] cnt, cnt_n, d_val;
  always_comb begin
    d_val   = (i_dead_time < DT_WIDTH'(DT_MIN)) ? DT_WIDTH'(DT_MIN) : i_dead_time;
    state_n = state;
    cnt_n   = cnt;
    if (i_force_off) begin
      state_n = OFF;
      cnt_n   = '0;
    end else begin
      case (state)
        OFF: begin
          state_n = DEAD_TO_LOW;
          cnt_n   = d_val;
        end
        DEAD_TO_LOW: begin
          if (cnt <= DT_WIDTH'(1)) state_n = LOW_ON;
          else cnt_n = cnt - 1'b1;
        end
        LOW_ON: begin
          if (i_cmd) begin
            state_n = DEAD_TO_HIGH;
            cnt_n   = d_val;
          end
        end
        DEAD_TO_HIGH: begin
          // a command that drops before expiry aborts back through a full dead time
          if (!i_cmd) begin
            state_n = DEAD_TO_LOW;
            cnt_n   = d_val;
          end else if (cnt <= DT_WIDTH'(1)) state_n = HIGH_ON;
          else cnt_n = cnt - 1'b1;
        end
        HIGH_ON: begin
          if (!i_cmd) begin
            state_n = DEAD_TO_LOW;
            cnt_n   = d_val;
          end
        end
        default: begin
          state_n = OFF;
          cnt_n   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= OFF;
      cnt    <= '0;
      o_high <= 1'b0;
      o_low  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      o_high <= (state_n == HIGH_ON);
      o_low  <= (state_n == LOW_ON);
    end
  end
endmodule

// File: rtl/full_bridge_gate_driver.sv
// full_bridge_gate_driver: PWM to H-bridge gate commands with direction steering, dead time and latched fault
module full_bridge_gate_driver
  import full_bridge_pkg::*;
#(
  parameter int DT_WIDTH    = DT_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_pwm,
  input  logic                i_enable,
  input  logic                i_direction,
  input  logic [DT_WIDTH-1:0] i_dead_time,
  input  logic                i_fault,
  input  logic                i_fault_clear,
  output logic                o_gate_ah,
  output logic                o_gate_al,
  output logic                o_gate_bh,
  output logic                o_gate_bl,
  output logic                o_fault
);
  logic [SYNC_STAGES-1:0] p_sync, f_sync;
  logic p_s, f_s, cmd_a, cmd_b, force_off;
  assign p_s       = p_sync[SYNC_STAGES-1];
  assign f_s       = f_sync[SYNC_STAGES-1];
  assign force_off = ~i_enable | o_fault;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      p_sync  <= '0;
      f_sync  <= '0;
      cmd_a   <= 1'b0;
      cmd_b   <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      p_sync  <= {p_sync[SYNC_STAGES-2:0], i_pwm};
      f_sync  <= {f_sync[SYNC_STAGES-2:0], i_fault};
      cmd_a   <= p_s & ~i_direction;
      cmd_b   <= p_s & i_direction;
      o_fault <= f_s | (o_fault & ~i_fault_clear);
    end
  end
  deadtime_leg #(.DT_WIDTH(DT_WIDTH)) u_leg_a (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd(cmd_a), .i_force_off(force_off),
    .i_dead_time(i_dead_time), .o_high(o_gate_ah), .o_low(o_gate_al)
  );
  deadtime_leg #(.DT_WIDTH(DT_WIDTH)) u_leg_b (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_cmd(cmd_b), .i_force_off(force_off),
    .i_dead_time(i_dead_time), .o_high(o_gate_bh), .o_low(o_gate_bl)
  );
endmodule
